mem_bus_arbiter: RTL and testbench

Parametrised memory/IO bus arbiter and decoder that connects `NUM_MASTERS` byte-wide requesters (CPU ports, HCI debug port, future DMA) to the internal RAM and the HCI IO window. It generalises the fixed two-way CPU/HCI mux with four additions:
- round-robin arbitration;
- an absolute-priority debug master;
- per-master lock for atomic multi-byte sequences;
- IO-full backpressure and a latency-tracked read-return pipeline.

It sits between the masters and `ram`/`hci` in the top level.

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/bus_rr_arbiter.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the memory/IO bus arbiter: IO-window decode, target codes, io_sel width.
package mem_bus_arbiter_pkg;

    // addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] equal to this selects the HCI IO window
    localparam logic [1:0] IO_WINDOW = 2'b11;

    // io_sel carries addr[2:0]
    localparam int unsigned IO_SEL_W = 3;

    typedef enum logic {
        TGT_RAM = 1'b0,
        TGT_IO  = 1'b1
    } tgt_e;

    // Master-id width; kept at least one bit so single-bit ids stay legal
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Grant selection: lock owner first, then the absolute-priority master, then round-robin.
module bus_rr_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ID_W        = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] elig,
    input  logic [ID_W-1:0]        prio_idx,
    input  logic                   lock_valid,
    input  logic [ID_W-1:0]        lock_owner,
    input  logic [ID_W-1:0]        rr_ptr,
    output logic [NUM_MASTERS-1:0] gnt,
    output logic [ID_W-1:0]        rr_ptr_next
);

    int unsigned idx;
    logic        found;

    // One-hot grant and pointer advance; pointer only moves on a round-robin grant
    always_comb begin
        gnt         = '0;
        rr_ptr_next = rr_ptr;
        idx         = 0;
        found       = 1'b0;
        if (lock_valid) begin
            // Owner keeps the bus even while idle or stalled
            gnt[lock_owner] = elig[lock_owner];
        end else if (elig[prio_idx]) begin
            gnt[prio_idx] = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
                idx = (32'(rr_ptr) + k) % NUM_MASTERS;
                if (!found && elig[ID_W'(idx)]) begin
                    found             = 1'b1;
                    gnt[ID_W'(idx)]   = 1'b1;
                    rr_ptr_next       = ID_W'((idx + 1) % NUM_MASTERS);
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory/IO bus arbiter and decoder: N byte-wide masters onto RAM and the HCI IO window,
// with a latency-matched read-return pipeline.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned PRIO_MASTER    = 0,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_lock,
    input  logic [NUM_MASTERS-1:0]            m_wr,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*8-1:0]          m_wdata,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [7:0]                        m_rdata,
    output logic                              ram_en,
    output logic                              ram_r_nw,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_a,
    output logic [7:0]                        ram_din,
    input  logic [7:0]                        ram_dout,
    output logic                              io_en,
    output logic                              io_wr,
    output logic [IO_SEL_W-1:0]               io_sel,
    output logic [7:0]                        io_din,
    input  logic [7:0]                        io_dout,
    input  logic                              io_full
);

    localparam int unsigned ID_W = id_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] is_io;
    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] gnt;
    logic                   gnt_any;
    logic [ID_W-1:0]        gnt_id;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [7:0]             sel_wdata;
    logic                   sel_wr;
    logic                   sel_lock;
    tgt_e                   sel_tgt;

    logic [ID_W-1:0]         rr_ptr_q;
    logic [ID_W-1:0]         rr_ptr_next;
    logic                    lock_valid_q;
    logic [ID_W-1:0]         lock_owner_q;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    tgt_e                    pipe_tgt_q [READ_LATENCY];
    logic [ID_W-1:0]         pipe_id_q  [READ_LATENCY];

    logic unused_sel_addr;
    assign unused_sel_addr = ^sel_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];

    // Decode target per master; IO writes stall while the IO FIFO is full; nothing wins in reset
    always_comb begin
        is_io = '0;
        elig  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            is_io[i] = (m_addr[i*ADDR_WIDTH + RAM_ADDR_WIDTH -: 2] == IO_WINDOW);
            elig[i]  = rst_n_in & m_req[i] & ~(m_wr[i] & is_io[i] & io_full);
        end
    end

    bus_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_W        (ID_W)
    ) u_arb (
        .elig        (elig),
        .prio_idx    (ID_W'(PRIO_MASTER)),
        .lock_valid  (lock_valid_q),
        .lock_owner  (lock_owner_q),
        .rr_ptr      (rr_ptr_q),
        .gnt         (gnt),
        .rr_ptr_next (rr_ptr_next)
    );

    // Mux the granted master's request fields
    always_comb begin
        gnt_id    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        sel_lock  = 1'b0;
        sel_tgt   = TGT_RAM;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt[i]) begin
                gnt_id    = ID_W'(i);
                sel_addr  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = m_wdata[i*8 +: 8];
                sel_wr    = m_wr[i];
                sel_lock  = m_lock[i];
                sel_tgt   = is_io[i] ? TGT_IO : TGT_RAM;
            end
        end
    end

    assign gnt_any  = |gnt;
    assign m_gnt    = gnt;
    assign ram_en   = gnt_any & (sel_tgt == TGT_RAM);
    assign io_en    = gnt_any & (sel_tgt == TGT_IO);
    assign ram_r_nw = ~(gnt_any & sel_wr);
    assign io_wr    = gnt_any & sel_wr;
    assign ram_a    = sel_addr[RAM_ADDR_WIDTH-1:0];
    assign io_sel   = sel_addr[IO_SEL_W-1:0];
    assign ram_din  = sel_wdata;
    assign io_din   = sel_wdata;

    // Arbitration state: pointer and lock follow every accepted access
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_next;
            if (gnt_any) begin
                lock_valid_q <= sel_lock;
                lock_owner_q <= gnt_id;
            end
        end
    end

    // Read-return shift pipeline; reset drops any in-flight reads
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_tgt_q[k] <= TGT_RAM;
                pipe_id_q[k]  <= '0;
            end
        end else begin
            pipe_vld_q[0] <= gnt_any & ~sel_wr;
            pipe_tgt_q[0] <= sel_tgt;
            pipe_id_q[0]  <= gnt_id;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_tgt_q[k] <= pipe_tgt_q[k-1];
                pipe_id_q[k]  <= pipe_id_q[k-1];
            end
        end
    end

    // Return data comes from the target recorded at grant time, not the current decode
    always_comb begin
        m_rvalid = '0;
        m_rdata  = '0;
        if (pipe_vld_q[READ_LATENCY-1]) begin
            m_rvalid[pipe_id_q[READ_LATENCY-1]] = 1'b1;
            m_rdata = (pipe_tgt_q[READ_LATENCY-1] == TGT_IO) ? io_dout : ram_dout;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter at read latencies 1 and 3.
module tb_mem_bus_arbiter;

    localparam int N    = 3;
    localparam int PRIO = 0;
    localparam int AW   = 32;
    localparam int RAW  = 17;

    logic clk;
    logic rst_n;
    logic env_rst_n;
    logic [N-1:0]    m_req, m_lock, m_wr;
    logic [N*AW-1:0] m_addr;
    logic [N*8-1:0]  m_wdata;
    logic            io_full;

    logic [N-1:0]   gnt1, rvalid1, gnt3, rvalid3;
    logic [7:0]     rdata1, rdata3;
    logic           ram_en1, ram_r_nw1, io_en1, io_wr1;
    logic           ram_en3, ram_r_nw3, io_en3, io_wr3;
    logic [RAW-1:0] ram_a1, ram_a3;
    logic [7:0]     ram_din1, ram_dout1, io_din1, io_dout1;
    logic [7:0]     ram_din3, ram_dout3, io_din3, io_dout3;
    logic [2:0]     io_sel1, io_sel3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mem_bus_arbiter #(.NUM_MASTERS(N), .PRIO_MASTER(PRIO), .ADDR_WIDTH(AW),
                      .RAM_ADDR_WIDTH(RAW), .READ_LATENCY(1)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .m_req(m_req), .m_lock(m_lock), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(gnt1), .m_rvalid(rvalid1), .m_rdata(rdata1),
        .ram_en(ram_en1), .ram_r_nw(ram_r_nw1), .ram_a(ram_a1), .ram_din(ram_din1),
        .ram_dout(ram_dout1), .io_en(io_en1), .io_wr(io_wr1), .io_sel(io_sel1),
        .io_din(io_din1), .io_dout(io_dout1), .io_full(io_full)
    );

    mem_bus_arbiter #(.NUM_MASTERS(N), .PRIO_MASTER(PRIO), .ADDR_WIDTH(AW),
                      .RAM_ADDR_WIDTH(RAW), .READ_LATENCY(3)) u_dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .m_req(m_req), .m_lock(m_lock), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(gnt3), .m_rvalid(rvalid3), .m_rdata(rdata3),
        .ram_en(ram_en3), .ram_r_nw(ram_r_nw3), .ram_a(ram_a3), .ram_din(ram_din3),
        .ram_dout(ram_dout3), .io_en(io_en3), .io_wr(io_wr3), .io_sel(io_sel3),
        .io_din(io_din3), .io_dout(io_dout3), .io_full(io_full)
    );

    // Unwritten locations read back a fixed address-derived pattern
    function automatic logic [7:0] ram_init(input int idx);
        return 8'(idx * 7 + 3);
    endfunction
    function automatic logic [7:0] io_init(input int idx);
        return 8'(8'h90 + idx);
    endfunction

    // Target models, one set per DUT; reads complete after the DUT's latency
    logic [7:0]   env_ram1 [256], env_ram3 [256], env_io1 [8], env_io3 [8];
    logic [255:0] env_ram_vld1, env_ram_vld3;
    logic [7:0]   env_io_vld1, env_io_vld3;
    logic [7:0]   ram_rd1, io_rd1, ram_rd3, io_rd3;
    logic [7:0]   ram_p3 [3], io_p3 [3];

    assign ram_rd1 = env_ram_vld1[ram_a1[7:0]] ? env_ram1[ram_a1[7:0]] : ram_init(int'(ram_a1[7:0]));
    assign io_rd1  = env_io_vld1[io_sel1] ? env_io1[io_sel1] : io_init(int'(io_sel1));
    assign ram_rd3 = env_ram_vld3[ram_a3[7:0]] ? env_ram3[ram_a3[7:0]] : ram_init(int'(ram_a3[7:0]));
    assign io_rd3  = env_io_vld3[io_sel3] ? env_io3[io_sel3] : io_init(int'(io_sel3));
    assign ram_dout3 = ram_p3[2];
    assign io_dout3  = io_p3[2];

    always_ff @(posedge clk) begin
        if (ram_en1 && !ram_r_nw1) env_ram1[ram_a1[7:0]] <= ram_din1;
        if (io_en1 && io_wr1)      env_io1[io_sel1]      <= io_din1;
        if (ram_en3 && !ram_r_nw3) env_ram3[ram_a3[7:0]] <= ram_din3;
        if (io_en3 && io_wr3)      env_io3[io_sel3]      <= io_din3;
        ram_dout1 <= (ram_en1 && ram_r_nw1) ? ram_rd1 : 8'($urandom);
        io_dout1  <= (io_en1 && !io_wr1) ? io_rd1 : 8'($urandom);
        ram_p3[0] <= (ram_en3 && ram_r_nw3) ? ram_rd3 : 8'($urandom);
        io_p3[0]  <= (io_en3 && !io_wr3) ? io_rd3 : 8'($urandom);
        ram_p3[1] <= ram_p3[0];
        ram_p3[2] <= ram_p3[1];
        io_p3[1]  <= io_p3[0];
        io_p3[2]  <= io_p3[1];
    end

    always_ff @(posedge clk or negedge env_rst_n) begin
        if (!env_rst_n) begin
            env_ram_vld1 <= '0;
            env_io_vld1  <= '0;
            env_ram_vld3 <= '0;
            env_io_vld3  <= '0;
        end else begin
            if (ram_en1 && !ram_r_nw1) env_ram_vld1[ram_a1[7:0]] <= 1'b1;
            if (io_en1 && io_wr1)      env_io_vld1[io_sel1]      <= 1'b1;
            if (ram_en3 && !ram_r_nw3) env_ram_vld3[ram_a3[7:0]] <= 1'b1;
            if (io_en3 && io_wr3)      env_io_vld3[io_sel3]      <= 1'b1;
        end
    end

    // Reference model state
    int           r_rr, r_owner, last_g, cyc;
    logic         r_lock_v;
    logic [7:0]   ref_ram [256];
    logic [255:0] ref_ram_vld;
    logic [7:0]   ref_io [8];
    logic [7:0]   ref_io_vld;
    int           h_v [4], h_id [4], h_d [4];  // h_x[k]: read granted k cycles ago
    int           n_checks, n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return m_addr[i*AW +: AW];
    endfunction

    function automatic logic is_io_a(input logic [AW-1:0] a);
        return a[RAW:RAW-1] == 2'b11;
    endfunction

    // Who wins this cycle: owner only if locked; else debug master; else scan from pointer
    function automatic int ref_pick(input logic [N-1:0] elig);
        if (r_lock_v) return elig[r_owner] ? r_owner : -1;
        if (elig[PRIO]) return PRIO;
        for (int k = 0; k < N; k++) begin
            if (elig[(r_rr + k) % N]) return (r_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic ref_reset();
        r_rr = 0;
        r_lock_v = 1'b0;
        r_owner = 0;
        for (int k = 0; k < 4; k++) begin
            h_v[k] = 0;
            h_id[k] = 0;
            h_d[k] = 0;
        end
    endtask

    // One bus cycle: inputs already driven at posedge+1; sample at negedge
    task automatic step();
        logic [N-1:0]  elig;
        logic [AW-1:0] a;
        logic          wrg, io;
        logic [7:0]    d, rd;
        int            g;
        wrg = 1'b0;
        rd  = 8'h00;
        @(negedge clk);
        check_eq("rvalid_l1", 32'(rvalid1), h_v[1] != 0 ? 32'(1 << h_id[1]) : 32'(0));
        check_eq("rdata_l1", 32'(rdata1), h_v[1] != 0 ? 32'(h_d[1]) : 32'(0));
        check_eq("rvalid_l3", 32'(rvalid3), h_v[3] != 0 ? 32'(1 << h_id[3]) : 32'(0));
        check_eq("rdata_l3", 32'(rdata3), h_v[3] != 0 ? 32'(h_d[3]) : 32'(0));
        for (int i = 0; i < N; i++)
            elig[i] = m_req[i] && !(m_wr[i] && is_io_a(addr_of(i)) && io_full);
        g = ref_pick(elig);
        check_eq("gnt_l1", 32'(gnt1), g >= 0 ? 32'(1 << g) : 32'(0));
        check_eq("gnt_l3", 32'(gnt3), g >= 0 ? 32'(1 << g) : 32'(0));
        if (g >= 0) begin
            a   = addr_of(g);
            wrg = m_wr[g];
            d   = m_wdata[g*8 +: 8];
            io  = is_io_a(a);
            check_eq("ram_en", 32'(ram_en1), 32'(!io));
            check_eq("io_en", 32'(io_en1), 32'(io));
            check_eq("ram_en_l3", 32'(ram_en3), 32'(!io));
            check_eq("io_en_l3", 32'(io_en3), 32'(io));
            check_eq("ram_r_nw", 32'(ram_r_nw1), 32'(!wrg));
            check_eq("io_wr", 32'(io_wr1), 32'(wrg));
            if (io) check_eq("io_sel", 32'(io_sel1), 32'(a[2:0]));
            else    check_eq("ram_a", 32'(ram_a1), 32'(a[RAW-1:0]));
            if (wrg) check_eq("din", 32'(io ? io_din1 : ram_din1), 32'(d));
            if (io) begin
                if (wrg) begin
                    ref_io[a[2:0]] = d;
                    ref_io_vld[a[2:0]] = 1'b1;
                end else begin
                    rd = ref_io_vld[a[2:0]] ? ref_io[a[2:0]] : io_init(int'(a[2:0]));
                end
            end else begin
                if (wrg) begin
                    ref_ram[a[7:0]] = d;
                    ref_ram_vld[a[7:0]] = 1'b1;
                end else begin
                    rd = ref_ram_vld[a[7:0]] ? ref_ram[a[7:0]] : ram_init(int'(a[7:0]));
                end
            end
            if (!r_lock_v && g != PRIO) r_rr = (g + 1) % N;
            r_lock_v = m_lock[g];
            r_owner  = g;
        end else begin
            check_eq("idle_ram_en", 32'(ram_en1), 32'(0));
            check_eq("idle_io_en", 32'(io_en1), 32'(0));
            check_eq("idle_r_nw", 32'(ram_r_nw1), 32'(1));
            check_eq("idle_io_en_l3", 32'(io_en3), 32'(0));
        end
        for (int k = 3; k >= 2; k--) begin
            h_v[k]  = h_v[k-1];
            h_id[k] = h_id[k-1];
            h_d[k]  = h_d[k-1];
        end
        h_v[1]  = (g >= 0 && !wrg) ? 1 : 0;
        h_id[1] = g;
        h_d[1]  = int'(rd);
        last_g  = g;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_gnt"}, 32'(gnt1), 32'(0));
        check_eq({tag, "_rvalid"}, 32'(rvalid1), 32'(0));
        check_eq({tag, "_rdata"}, 32'(rdata1), 32'(0));
        check_eq({tag, "_gnt_l3"}, 32'(gnt3), 32'(0));
        check_eq({tag, "_rvalid_l3"}, 32'(rvalid3), 32'(0));
        check_eq({tag, "_rdata_l3"}, 32'(rdata3), 32'(0));
        check_eq({tag, "_en"}, 32'({ram_en1, io_en1, ram_en3, io_en3}), 32'(0));
        check_eq({tag, "_r_nw"}, 32'(ram_r_nw1), 32'(1));
    endtask

    task automatic set_m(input int i, input logic rq, input logic lk, input logic w,
                         input logic [AW-1:0] a, input logic [7:0] d);
        m_req[i]          = rq;
        m_lock[i]         = lk;
        m_wr[i]           = w;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*8 +: 8] = d;
    endtask

    task automatic new_txn(input int i);
        logic [AW-1:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            a[RAW:RAW-1] = 2'b11;
        end else begin
            a[RAW:RAW-1] = 2'($urandom_range(0, 2));
            a[7:0] = 8'($urandom_range(0, 15));
        end
        set_m(i, 1'b1, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        last_g   = -1;
        ref_ram_vld = '0;
        ref_io_vld  = '0;
        ref_reset();
        rst_n = 1'b0;
        env_rst_n = 1'b0;
        m_req = '0; m_lock = '0; m_wr = '0; m_addr = '0; m_wdata = '0;
        io_full = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        env_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin between masters 1 and 2
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h20, 8'h00);
        set_m(2, 1'b1, 1'b0, 1'b0, 32'h40, 8'h00);
        for (int c = 0; c < 6; c++) begin
            step();
            if (last_g > 0) m_addr[last_g*AW +: AW] = addr_of(last_g) + 1;
        end
        // Debug master takes over, then round-robin resumes
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h60, 8'h00);
        repeat (3) step();
        m_req[0] = 1'b0;
        repeat (3) step();

        // IO write stalled by io_full while master 2 reads RAM
        m_req = '0;
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h30004, 8'h77);
        set_m(2, 1'b1, 1'b0, 1'b0, 32'h80, 8'h00);
        io_full = 1'b1;
        repeat (5) step();
        io_full = 1'b0;
        step();
        m_req = '0;

        // Locked 4-byte write burst from master 2; master 1 waits
        set_m(2, 1'b1, 1'b1, 1'b1, 32'h100, 8'hA0);
        step();
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h101, 8'h00);
        for (int k = 1; k < 4; k++) begin
            set_m(2, 1'b1, k < 3, 1'b1, 32'h100 + k, 8'(8'hA0 + k));
            step();
        end
        m_req[2] = 1'b0;
        repeat (2) step();
        m_req = '0;

        // IO read then RAM read, returns in order through the delayed target select
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h30000, 8'h00);
        step();
        m_req[1] = 1'b0;
        set_m(2, 1'b1, 1'b0, 1'b0, 32'h10, 8'h00);
        step();
        m_req[2] = 1'b0;
        repeat (3) step();

        // Reset one cycle after a read grant; pointer left at 2 beforehand
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h44, 8'h00);
        step();
        rst_n = 1'b0;
        m_req = '0;
        ref_reset();
        repeat (3) begin
            @(negedge clk);
            check_idle("midrst");
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h45, 8'h00);
        set_m(2, 1'b1, 1'b0, 1'b0, 32'h46, 8'h00);
        repeat (4) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            io_full = ($urandom_range(0, 2) == 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (last_g == i) begin
                    if ($urandom_range(0, 3) != 0) new_txn(i);
                    else m_req[i] = 1'b0;
                end else if (!m_req[i]) begin
                    if ($urandom_range(0, (i == PRIO) ? 7 : 2) == 0) new_txn(i);
                end else if ($urandom_range(0, 49) == 0) begin
                    m_req[i] = 1'b0;
                end
            end
        end
        m_req = '0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
